// File: rtl/ccd_line_timing_gen_pkg.sv
// ---------------------------------------------------------------------------
// ccd_timing_pkg
// Shared definitions for the two-phase linear CCD line timing generator:
// sequencer state encoding, the half-period floor and default window
// placement used by ccd_line_timing_gen.
// ---------------------------------------------------------------------------
package ccd_timing_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_LOAD  = 2'd2,
        ST_TRAN  = 2'd3
    } ccd_state_e;

    // Shortest f1 half-period that still leaves room for rs/cp/sample slots.
    localparam int unsigned MIN_HALF_PERIOD = 4;

    localparam int unsigned DEF_PXL_W      = 12;
    localparam int unsigned DEF_DIV_W      = 10;
    localparam int unsigned DEF_SH_START   = 60;
    localparam int unsigned DEF_SH_STOP    = 211;
    localparam int unsigned DEF_RS_START   = 1;
    localparam int unsigned DEF_RS_WIDTH   = 10;
    localparam int unsigned DEF_CP_START   = 11;
    localparam int unsigned DEF_CP_WIDTH   = 10;
    localparam int unsigned DEF_SAMPLE_POS = 22;

endpackage

// File: rtl/ccd_line_timing_gen_if.sv
// ---------------------------------------------------------------------------
// ccd_line_timing_gen_if
// Control/status and sensor-pin bundle of the CCD line timing generator.
//   master : acquisition controller side (drives start/cont/operands)
//   slave  : timing generator side (drives sensor pins, busy, strobes)
// PXL_W/DIV_W must match the generator instance parameters.
// ---------------------------------------------------------------------------
interface ccd_line_timing_gen_if #(
    parameter int unsigned PXL_W = 12,
    parameter int unsigned DIV_W = 10
);
    logic             start;
    logic             cont;
    logic [DIV_W-1:0] half_period;
    logic [PXL_W-1:0] line_pixels;
    logic [DIV_W-1:0] load_cycles;
    logic             sh;
    logic             f1;
    logic             f2;
    logic             f2b;
    logic             rs;
    logic             cp;
    logic             busy;
    logic             line_done;
    logic             pxl_valid;
    logic [PXL_W-1:0] pxl_idx;

    modport master (
        output start, cont, half_period, line_pixels, load_cycles,
        input  sh, f1, f2, f2b, rs, cp, busy, line_done, pxl_valid, pxl_idx
    );

    modport slave (
        input  start, cont, half_period, line_pixels, load_cycles,
        output sh, f1, f2, f2b, rs, cp, busy, line_done, pxl_valid, pxl_idx
    );
endinterface

// File: rtl/ccd_line_timing_gen_phase_window.sv
// ---------------------------------------------------------------------------
// ccd_phase_window
// Compare-and-clip window decoder: level is high while
//   start <= pos < start + width  and  pos <= limit.
// The end is computed one bit wider so start+width never wraps.
// Ports: pos, start, width, limit (W bits) in; level out.
// ---------------------------------------------------------------------------
module ccd_phase_window #(
    parameter int unsigned W = 10
) (
    input  logic [W-1:0] pos,
    input  logic [W-1:0] start,
    input  logic [W-1:0] width,
    input  logic [W-1:0] limit,
    output logic         level
);
    logic [W:0] stop_s;

    assign stop_s = {1'b0, start} + {1'b0, width};
    assign level  = ({1'b0, pos} >= {1'b0, start}) &&
                    ({1'b0, pos} <  stop_s) &&
                    (pos <= limit);
endmodule

// File: rtl/ccd_line_timing_gen.sv
// ---------------------------------------------------------------------------
// ccd_line_timing_gen
// Two-phase linear CCD line sequencer (IDLE -> SETUP -> LOAD -> TRAN) with
// run-time half-period, pixel count and load length, single-shot or
// continuous lines, and an optional per-pixel ADC sample strobe.
// Ports: sys_clk, sys_rst_n (async active-low), bus (ccd_line_timing_gen_if
// slave: start/cont/operands in; sh, f1, f2, f2b, rs, cp, busy, line_done,
// pxl_valid, pxl_idx out).
// Build option: CCD_SAMPLE_STROBE_EN enables pxl_valid/pxl_idx; otherwise
// both are tied to zero and sensor timing is unchanged.
// ---------------------------------------------------------------------------
module ccd_line_timing_gen
    import ccd_timing_pkg::*;
#(
    parameter int unsigned PXL_W      = DEF_PXL_W,
    parameter int unsigned DIV_W      = DEF_DIV_W,
    parameter int unsigned SH_START   = DEF_SH_START,
    parameter int unsigned SH_STOP    = DEF_SH_STOP,
    parameter int unsigned RS_START   = DEF_RS_START,
    parameter int unsigned RS_WIDTH   = DEF_RS_WIDTH,
    parameter int unsigned CP_START   = DEF_CP_START,
    parameter int unsigned CP_WIDTH   = DEF_CP_WIDTH,
    parameter int unsigned SAMPLE_POS = DEF_SAMPLE_POS
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    ccd_line_timing_gen_if.slave  bus
);
    localparam logic [DIV_W-1:0] HP_MIN   = DIV_W'(MIN_HALF_PERIOD);
    // sh is strictly inside (SH_START, SH_STOP): first high count is SH_START+1.
    localparam logic [DIV_W-1:0] SH_LO    = DIV_W'(SH_START + 1);
    localparam logic [DIV_W-1:0] SH_LEN   = DIV_W'(SH_STOP - SH_START - 1);
    localparam logic [DIV_W-1:0] RS_LO    = DIV_W'(RS_START);
    localparam logic [DIV_W-1:0] RS_LEN   = DIV_W'(RS_WIDTH);
    localparam logic [DIV_W-1:0] CP_LO    = DIV_W'(CP_START);
    localparam logic [DIV_W-1:0] CP_LEN   = DIV_W'(CP_WIDTH);

    ccd_state_e       state_r, state_s;
    logic [DIV_W-1:0] cnt_r, cnt_s;
    logic [DIV_W-1:0] div_r, div_s;
    logic [PXL_W-1:0] pix_r, pix_s;
    logic             f1_r, f1_s;
    logic [DIV_W-1:0] hp_r, load_r;
    logic [PXL_W-1:0] npix_r;
    logic             sh_r, rs_r, cp_r, busy_r, line_done_r;
    logic             pxl_valid_r;
    logic [PXL_W-1:0] pxl_idx_r;

    logic [DIV_W-1:0] hp_m1_s, load_m1_s;
    logic             cnt_last_s, div_wrap_s;
    logic             sh_win_s, rs_win_s, cp_win_s;

    assign hp_m1_s    = hp_r - DIV_W'(1);
    assign load_m1_s  = load_r - DIV_W'(1);
    // A zero load length degenerates to a single-cycle phase.
    assign cnt_last_s = ({1'b0, cnt_r} + {{DIV_W{1'b0}}, 1'b1}) >= {1'b0, load_r};
    assign div_wrap_s = (div_r == hp_m1_s);

    // Next sequencer position; outputs are decoded from it so they register in step.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        div_s   = div_r;
        pix_s   = pix_r;
        f1_s    = f1_r;
        case (state_r)
            ST_IDLE: begin
                f1_s = 1'b0;
                if (bus.start) begin
                    state_s = ST_SETUP;
                    cnt_s   = '0;
                    div_s   = '0;
                    pix_s   = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_last_s) begin
                    state_s = ST_LOAD;
                    cnt_s   = '0;
                    f1_s    = 1'b1;
                end else begin
                    cnt_s   = cnt_r + DIV_W'(1);
                    f1_s    = 1'b0;
                end
            end
            ST_LOAD: begin
                if (cnt_last_s) begin
                    // TRAN opens with the f1-low half.
                    state_s = ST_TRAN;
                    cnt_s   = '0;
                    div_s   = '0;
                    pix_s   = '0;
                    f1_s    = 1'b0;
                end else begin
                    cnt_s   = cnt_r + DIV_W'(1);
                    f1_s    = 1'b1;
                end
            end
            ST_TRAN: begin
                if (div_wrap_s) begin
                    div_s = '0;
                    if (!f1_r) begin
                        // f1 rising edge advances the pixel counter.
                        f1_s  = 1'b1;
                        pix_s = pix_r + PXL_W'(1);
                    end else if (pix_r == npix_r) begin
                        state_s = bus.cont ? ST_SETUP : ST_IDLE;
                        cnt_s   = '0;
                        pix_s   = '0;
                        f1_s    = 1'b0;
                    end else begin
                        f1_s  = 1'b0;
                    end
                end else begin
                    div_s = div_r + DIV_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
                div_s   = '0;
                pix_s   = '0;
                f1_s    = 1'b0;
            end
        endcase
    end

    ccd_phase_window #(.W(DIV_W)) u_sh_win (
        .pos(cnt_s), .start(SH_LO), .width(SH_LEN), .limit(load_m1_s), .level(sh_win_s)
    );
    ccd_phase_window #(.W(DIV_W)) u_rs_win (
        .pos(div_s), .start(RS_LO), .width(RS_LEN), .limit(hp_m1_s), .level(rs_win_s)
    );
    ccd_phase_window #(.W(DIV_W)) u_cp_win (
        .pos(div_s), .start(CP_LO), .width(CP_LEN), .limit(hp_m1_s), .level(cp_win_s)
    );

    // Sequencer state, operand latch and registered sensor/handshake outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            div_r       <= '0;
            pix_r       <= '0;
            f1_r        <= 1'b0;
            hp_r        <= HP_MIN;
            npix_r      <= PXL_W'(1);
            load_r      <= '0;
            sh_r        <= 1'b0;
            rs_r        <= 1'b0;
            cp_r        <= 1'b0;
            busy_r      <= 1'b0;
            line_done_r <= 1'b0;
        end else begin
            if ((state_r == ST_IDLE) && bus.start) begin
                hp_r   <= (bus.half_period < HP_MIN) ? HP_MIN : bus.half_period;
                npix_r <= (bus.line_pixels == PXL_W'(0)) ? PXL_W'(1) : bus.line_pixels;
                load_r <= bus.load_cycles;
            end else begin
                hp_r   <= hp_r;
                npix_r <= npix_r;
                load_r <= load_r;
            end
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            div_r       <= div_s;
            pix_r       <= pix_s;
            f1_r        <= f1_s;
            sh_r        <= (state_s == ST_LOAD) && sh_win_s;
            rs_r        <= (state_s == ST_TRAN) && !f1_s && rs_win_s;
            cp_r        <= (state_s == ST_TRAN) && !f1_s && cp_win_s;
            busy_r      <= (state_s != ST_IDLE);
            line_done_r <= (state_s == ST_TRAN) && f1_s &&
                           (div_s == hp_m1_s) && (pix_s == npix_r);
        end
    end

`ifdef CCD_SAMPLE_STROBE_EN
    localparam logic [DIV_W-1:0] SAMP_POS = DIV_W'(SAMPLE_POS);
    logic [DIV_W-1:0] samp_s;

    assign samp_s = (SAMP_POS < hp_r) ? SAMP_POS : hp_m1_s;

    // ADC strobe once per f1-low half, tagged with the pixel being read.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pxl_valid_r <= 1'b0;
            pxl_idx_r   <= '0;
        end else begin
            pxl_valid_r <= (state_s == ST_TRAN) && !f1_s && (div_s == samp_s);
            pxl_idx_r   <= pix_s;
        end
    end
`else
    assign pxl_valid_r = 1'b0;
    assign pxl_idx_r   = '0;
`endif

    assign bus.sh        = sh_r;
    assign bus.f1        = f1_r;
    assign bus.f2        = ~f1_r;
    assign bus.f2b       = ~f1_r;
    assign bus.rs        = rs_r;
    assign bus.cp        = cp_r;
    assign bus.busy      = busy_r;
    assign bus.line_done = line_done_r;
    assign bus.pxl_valid = pxl_valid_r;
    assign bus.pxl_idx   = pxl_idx_r;

endmodule

// File: tb/tb_ccd_line_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_ccd_line_timing_gen
// Self-checking bench for ccd_line_timing_gen. Expected traces are computed
// per cycle from the line arithmetic (setup/load/transfer offsets, pixel
// period 2*hp), independent of the design's counters.
// ---------------------------------------------------------------------------
module tb_ccd_line_timing_gen;

`ifdef CCD_SAMPLE_STROBE_EN
    localparam bit STROBE = 1'b1;
`else
    localparam bit STROBE = 1'b0;
`endif

    logic sys_clk;
    logic sys_rst_n;
    int   n_checks;
    int   n_errors;

    // Captured output vectors, one per cycle after start acceptance.
    logic [20:0] cap_q[$];

    ccd_line_timing_gen_if #(.PXL_W(12), .DIV_W(10)) bus ();

    ccd_line_timing_gen dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus      (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // {busy, line_done, sh, f1, f2, f2b, rs, cp, pxl_valid, pxl_idx[11:0]}
    function automatic logic [20:0] act_vec();
        return {bus.busy, bus.line_done, bus.sh, bus.f1, bus.f2, bus.f2b,
                bus.rs, bus.cp, bus.pxl_valid, bus.pxl_idx};
    endfunction

    function automatic int clamp_hp(input int hp);
        return (hp < 4) ? 4 : hp;
    endfunction

    function automatic int clamp_np(input int np);
        return (np == 0) ? 1 : np;
    endfunction

    // Expected outputs at cycle t after acceptance (t=0 is the first busy cycle).
    function automatic logic [20:0] exp_vec(input int t, input int hp, input int np,
                                            input int ld, input int nl);
        int per, ln, o, u, r, samp;
        logic b_e, d_e, sh_e, f1_e, rs_e, cp_e, v_e;
        logic [11:0] idx_e;
        per = 2 * ld + 2 * hp * np;
        ln = t / per;
        o = t % per;
        b_e = 1'b0; d_e = 1'b0; sh_e = 1'b0; f1_e = 1'b0;
        rs_e = 1'b0; cp_e = 1'b0; v_e = 1'b0; idx_e = 12'd0;
        if (ln < nl) begin
            b_e = 1'b1;
            if (o >= ld && o < 2 * ld) begin
                f1_e = 1'b1;
                sh_e = ((o - ld) > 60) && ((o - ld) < 211);
            end else if (o >= 2 * ld) begin
                u = o - 2 * ld;
                r = u % (2 * hp);
                samp = (22 < hp) ? 22 : hp - 1;
                f1_e = (r >= hp);
                if (r < hp) begin
                    rs_e = (r >= 1) && (r < 11);
                    cp_e = (r >= 11) && (r < 21);
                    v_e = (r == samp);
                    idx_e = 12'(u / (2 * hp));
                end
                d_e = (u == 2 * hp * np - 1);
            end
        end
        if (!STROBE) begin
            v_e = 1'b0;
            idx_e = 12'd0;
        end
        return {b_e, d_e, sh_e, f1_e, ~f1_e, ~f1_e, rs_e, cp_e, v_e, idx_e};
    endfunction

    // Issue a start with the given operands and capture ncyc output cycles.
    // drop_at: cycle at which cont is cleared; poke_at: cycle at which a
    // stray start and new random operands are presented (-1 disables).
    task automatic run_line(input int hp_in, input int np_in, input int ld_in,
                            input bit c_in, input int ncyc,
                            input int drop_at, input int poke_at);
        @(negedge sys_clk);
        bus.half_period = 10'(hp_in);
        bus.line_pixels = 12'(np_in);
        bus.load_cycles = 10'(ld_in);
        bus.cont = c_in;
        bus.start = 1'b1;
        @(negedge sys_clk);
        bus.start = 1'b0;
        cap_q.delete();
        for (int t = 0; t < ncyc; t++) begin
            cap_q.push_back(act_vec());
            if (t == drop_at) bus.cont = 1'b0;
            if (t == poke_at) begin
                bus.start = 1'b1;
                bus.half_period = 10'($urandom_range(0, 40));
                bus.line_pixels = 12'($urandom_range(0, 9));
                bus.load_cycles = 10'($urandom_range(1, 50));
            end else begin
                bus.start = 1'b0;
            end
            @(negedge sys_clk);
        end
        bus.start = 1'b0;
        bus.cont = 1'b0;
    endtask

    task automatic test_reset();
        logic [20:0] rv;
        sys_rst_n = 1'b0;
        bus.start = 1'b0;
        bus.cont = 1'b0;
        bus.half_period = 10'd5;
        bus.line_pixels = 12'd4;
        bus.load_cycles = 10'd10;
        repeat (3) @(negedge sys_clk);
        rv = act_vec();
        n_checks++;
        if (rv !== 21'b0_0_0_0_1_1_0_0_0_000000000000) begin
            n_errors++;
            $display("FAIL reset_state got=%h exp=%h", rv, 21'b0_0_0_0_1_1_0_0_0_000000000000);
        end
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic test_single_shot();
        int hp, np, ld, ncyc, sh_cnt, v_cnt, done_at, done_cnt;
        logic [20:0] a, e;
        hp = 5; np = 4; ld = 300;
        ncyc = 2 * ld + 2 * hp * np + 3;
        run_line(hp, np, ld, 1'b0, ncyc, -1, -1);
        sh_cnt = 0; v_cnt = 0; done_at = -1; done_cnt = 0;
        for (int t = 0; t < ncyc; t++) begin
            a = cap_q[t];
            e = exp_vec(t, hp, np, ld, 1);
            if (!e[12]) begin a[11:0] = 12'd0; e[11:0] = 12'd0; end
            n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL single_trace t=%0d got=%h exp=%h", t, a, e);
            end
            sh_cnt += int'(cap_q[t][18]);
            v_cnt += int'(cap_q[t][12]);
            if (cap_q[t][19]) begin done_cnt++; done_at = t; end
        end
        n_checks++;
        if (cap_q[0][20] !== 1'b1) begin
            n_errors++; $display("FAIL busy_at_n1 got=%b exp=1", cap_q[0][20]);
        end
        n_checks++;
        if (sh_cnt != 150) begin
            n_errors++; $display("FAIL sh_width got=%0d exp=150", sh_cnt);
        end
        n_checks++;
        if (done_cnt != 1 || done_at != 2 * ld + 40 - 1) begin
            n_errors++; $display("FAIL tran_len done_cnt=%0d done_at=%0d exp_at=%0d", done_cnt, done_at, 2 * ld + 39);
        end
        n_checks++;
        if (v_cnt != (STROBE ? 4 : 0)) begin
            n_errors++; $display("FAIL pxl_count got=%0d exp=%0d", v_cnt, STROBE ? 4 : 0);
        end
        n_checks++;
        if (cap_q[done_at + 1][20] !== 1'b0) begin
            n_errors++; $display("FAIL busy_fall got=%b exp=0", cap_q[done_at + 1][20]);
        end
    endtask

    task automatic test_clamp();
        int hp_in[2] = '{2, 4};
        int np_in[2] = '{3, 0};
        int ld_in[2] = '{6, 3};
        int hp, np, ncyc, rs_cnt, cp_cnt;
        logic [20:0] a, e;
        for (int k = 0; k < 2; k++) begin
            hp = clamp_hp(hp_in[k]);
            np = clamp_np(np_in[k]);
            ncyc = 2 * ld_in[k] + 2 * hp * np + 3;
            run_line(hp_in[k], np_in[k], ld_in[k], 1'b0, ncyc, -1, -1);
            rs_cnt = 0; cp_cnt = 0;
            for (int t = 0; t < ncyc; t++) begin
                a = cap_q[t];
                e = exp_vec(t, hp, np, ld_in[k], 1);
                if (!e[12]) begin a[11:0] = 12'd0; e[11:0] = 12'd0; end
                n_checks++;
                if (a !== e) begin
                    n_errors++;
                    $display("FAIL clamp_trace case=%0d t=%0d got=%h exp=%h", k, t, a, e);
                end
                rs_cnt += int'(cap_q[t][14]);
                cp_cnt += int'(cap_q[t][13]);
            end
            // hp=4: rs covers div 1..3 only, cp start lies beyond the half.
            n_checks++;
            if (rs_cnt != 3 * np || cp_cnt != 0) begin
                n_errors++;
                $display("FAIL clamp_clip case=%0d rs=%0d cp=%0d exp_rs=%0d exp_cp=0", k, rs_cnt, cp_cnt, 3 * np);
            end
        end
    endtask

    task automatic test_continuous();
        int hp, np, ld, per, ncyc, done_cnt;
        logic [20:0] a, e;
        hp = 4; np = 2; ld = 20;
        per = 2 * ld + 2 * hp * np;
        ncyc = 3 * per + 4;
        run_line(hp, np, ld, 1'b1, ncyc, 2 * per + ld, -1);
        done_cnt = 0;
        for (int t = 0; t < ncyc; t++) begin
            a = cap_q[t];
            e = exp_vec(t, hp, np, ld, 3);
            if (!e[12]) begin a[11:0] = 12'd0; e[11:0] = 12'd0; end
            n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL cont_trace t=%0d got=%h exp=%h", t, a, e);
            end
            done_cnt += int'(cap_q[t][19]);
        end
        n_checks++;
        if (done_cnt != 3) begin
            n_errors++; $display("FAIL cont_lines got=%0d exp=3", done_cnt);
        end
    endtask

    task automatic test_busy_ignore();
        int hp, np, ld, ncyc;
        logic [20:0] a, e;
        hp = 5; np = 3; ld = 10;
        ncyc = 2 * ld + 2 * hp * np + 4;
        run_line(hp, np, ld, 1'b0, ncyc, -1, 2 * ld + 7);
        for (int t = 0; t < ncyc; t++) begin
            a = cap_q[t];
            e = exp_vec(t, hp, np, ld, 1);
            if (!e[12]) begin a[11:0] = 12'd0; e[11:0] = 12'd0; end
            n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL busy_ignore t=%0d got=%h exp=%h", t, a, e);
            end
        end
    endtask

    task automatic test_random();
        int hp_in, np_in, ld, hp, np, ncyc;
        logic [20:0] a, e;
        for (int k = 0; k < 6; k++) begin
            hp_in = $urandom_range(0, 12);
            np_in = $urandom_range(0, 5);
            ld = $urandom_range(1, 240);
            hp = clamp_hp(hp_in);
            np = clamp_np(np_in);
            ncyc = 2 * ld + 2 * hp * np + 3;
            run_line(hp_in, np_in, ld, 1'b0, ncyc, -1, -1);
            for (int t = 0; t < ncyc; t++) begin
                a = cap_q[t];
                e = exp_vec(t, hp, np, ld, 1);
                if (!e[12]) begin a[11:0] = 12'd0; e[11:0] = 12'd0; end
                n_checks++;
                if (a !== e) begin
                    n_errors++;
                    $display("FAIL rand_trace hp=%0d np=%0d ld=%0d t=%0d got=%h exp=%h", hp_in, np_in, ld, t, a, e);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int hp, np, ld;
        logic [20:0] a;
        hp = 5; np = 4; ld = 20;
        // Stop inside the f1-low half of pixel 2.
        run_line(hp, np, ld, 1'b0, 2 * ld + 2 * hp * 2 + 2, -1, -1);
        a = act_vec();
        n_checks++;
        if (a[20] !== 1'b1) begin
            n_errors++; $display("FAIL pre_reset_busy got=%b exp=1", a[20]);
        end
        #2;
        sys_rst_n = 1'b0;
        #1;
        a = act_vec();
        n_checks++;
        if (a !== 21'b0_0_0_0_1_1_0_0_0_000000000000) begin
            n_errors++;
            $display("FAIL async_reset got=%h exp=%h", a, 21'b0_0_0_0_1_1_0_0_0_000000000000);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        a = act_vec();
        n_checks++;
        if (a !== 21'b0_0_0_0_1_1_0_0_0_000000000000) begin
            n_errors++;
            $display("FAIL post_reset_idle got=%h exp=%h", a, 21'b0_0_0_0_1_1_0_0_0_000000000000);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_single_shot();
        test_clamp();
        test_continuous();
        test_busy_ignore();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ccd_line_timing_gen.md
# ccd_line_timing_gen

Parametrised timing generator for two-phase linear CCD sensors. It generalises the fixed TCD1290D sequencer with run-time pixel count, shift-clock period and load width, plus single-shot or continuous line modes and a start/busy handshake. It also emits a per-pixel ADC sample strobe with a pixel index. It sits between the acquisition controller and the sensor pins / ADC capture logic.

## Interface
- PXL_W, 12: width of pixel count/index.
- DIV_W, 10: width of half-period and phase counters.
- SH_START, 60: SH rises when LOAD phase counter exceeds this.
- SH_STOP, 211: SH falls when LOAD phase counter reaches this.
- RS_START, 1; RS_WIDTH, 10: RS window start and length within the f1-low half.
- CP_START, 11; CP_WIDTH, 10: CP window start and length within the f1-low half.
- SAMPLE_POS, 22: pxl_valid position within the f1-low half.
- sys_clk  in  1  system clock, all logic on rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; honoured only in IDLE.
- cont  in  1  continuous mode; sampled at each line end.
- half_period  in  DIV_W  f1 half-period in clocks; latched at start.
- line_pixels  in  PXL_W  pixels per line; latched at start.
- load_cycles  in  DIV_W  SETUP and LOAD phase length; latched at start.
- sh, f1, f2, f2b, rs, cp  out  1  sensor drive.
- busy  out  1  high from cycle after accepted start until return to IDLE.
- line_done  out  1  one-cycle pulse on the last TRAN cycle of each line.
- pxl_valid  out  1  ADC sample strobe, one cycle per pixel.
- pxl_idx  out  PXL_W  index of the pixel strobed by pxl_valid, 0-based.

## Operation
- States: IDLE, SETUP, LOAD, TRAN.
- IDLE: f1=0, sh=rs=cp=0, phase counter 0. On start, latch operands, clamp half_period to a minimum of 4 and line_pixels to a minimum of 1, then go to SETUP.
- SETUP: f1=0 for load_cycles clocks, then go to LOAD.
- LOAD: f1=1 for load_cycles clocks. sh=1 while SH_START < cnt < SH_STOP. The window is clipped at load_cycles.
- TRAN: phase counter div runs 0..hp-1 and wraps. f1 toggles at each wrap. The first TRAN half is f1-low. Each pixel period is 2·hp clocks: a low half followed by a high half. The pixel counter increments on each f1 rising edge.
- TRAN exit: after line_pixels full periods (exactly 2·hp·line_pixels clocks), pulse line_done. Go to SETUP if cont=1, else IDLE. cont=0 during a line completes that line.
- rs and cp are high only in the f1-low half, over div ∈ [RS_START, RS_START+RS_WIDTH) and div ∈ [CP_START, CP_START+CP_WIDTH) respectively. Both are clipped at hp-1.
- pxl_valid fires at div==min(SAMPLE_POS, hp-1) in the f1-low half. pxl_idx equals the current pixel counter.
- f2 = f2b = ~f1, combinational from the f1 register.
- start while busy is ignored. Operand changes while busy have no effect.

## Timing
- Reset values: sh=f1=rs=cp=busy=line_done=pxl_valid=0, pxl_idx=0, f2=f2b=1. State is IDLE.
- Reset assertion mid-line forces reset values immediately, asynchronously.
- All outputs except f2/f2b are registered.
- start is accepted at edge N. busy=1 and SETUP begin at N+1. LOAD begins at N+1+load_cycles. TRAN begins at N+1+2·load_cycles.
- The f1 falling edge at TRAN entry coincides with the first TRAN cycle.
- Counters use modular arithmetic with no overflow. Comparisons are unsigned at DIV_W/PXL_W width.
- busy falls on the cycle after line_done when cont=0. It stays high in continuous mode.

## Configuration
- CCD_SAMPLE_STROBE_EN defined: pxl_valid and pxl_idx are generated as specified.
- CCD_SAMPLE_STROBE_EN undefined: pxl_valid and pxl_idx are tied to 0 and their logic is removed. Sensor timing is unchanged.

## Structure
- Package ccd_timing_pkg holds the state encoding (IDLE=0, SETUP=1, LOAD=2, TRAN=3), the minimum half-period constant 4, and default window parameters.
- One sub-module, ccd_phase_window: a compare-and-clip window decoder (start, width, limit → level). It is instantiated for sh, rs and cp.

## Test plan
- Reset: with sys_rst_n=0, f2=f2b=1 and all other outputs 0. Assert reset at TRAN pixel 2 → outputs return to reset values without waiting for a clock edge.
- Single shot with hp=5, pixels=4, load=300: busy at N+1; sh high for 150 clocks in LOAD; TRAN lasts 40 clocks; 4 pxl_valid with idx 0..3; one line_done; busy falls.
- Clamp: hp=2 behaves as hp=4 (8-clock pixel period). pixels=0 yields 1 pixel. With hp=4, rs/cp/pxl_valid clip at div=3.
- Continuous: cont=1 for 3 lines gives 3 line_done pulses with a SETUP+LOAD gap of 2·load each. Dropping cont during line 3 ends the run after line 3.
- start asserted while busy, and operand changes mid-line, do not alter the current line length or period.
- Build with CCD_SAMPLE_STROBE_EN undefined: pxl_valid never asserts, and sh/f1/rs/cp traces are identical to the enabled build.
